i2s_sample_tx: RTL

Upstream-fed I2S transmitter for the audio path. It accepts parallel 16-bit stereo samples over a valid/ready handshake and buffers them in a small FIFO. It serialises them MSB-first in standard I2S framing (one-bit delay after the word-clock edge) and drives the codec's master, word and bit clocks from a free-running divider off the system clock. It replaces the free-running noise source as the block that drives the codec pins; sample producers (mixer, test-tone generator) sit upstream of it.

---
 rtl/i2s_sample_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: stereo 16-bit I2S transmitter fed through a small sample FIFO.
// A free-running 9-bit divider generates the bit and word clocks. The shift
// register reloads from the FIFO once per 512-cycle frame, and out_data
// changes on sclk falling edges. Because the load happens one bit-slot before
// the left word is shifted out, the standard I2S one-bit delay falls out of the
// timing without any extra state.
module i2s_sample_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          inp_clock,
    input  logic                          inp_reset,
    input  logic                          inp_valid,
    input  logic [15:0]                   inp_left,
    input  logic [15:0]                   inp_right,
    output logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   out_level,
    output logic                          out_underrun,
    output logic                          out_mclk,
    output logic                          out_wclk,
    output logic                          out_sclk,
    output logic                          out_data
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Divider and serialiser state
    logic [8:0]    tick_reg;
    logic [31:0]   shreg_reg;
    logic [31:0]   shreg_next;
    logic          data_reg;
    logic          underrun_reg;

    // Sample FIFO: {left, right} per entry
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;

    logic          sclk_fall;
    logic          frame_load;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    // The last cycle of each sclk period is its falling edge.
    // The last cycle of the frame is also where the next pair is loaded.
    assign sclk_fall  = (tick_reg[3:0] == 4'hF);
    assign frame_load = (tick_reg == 9'h1FF);
    assign fifo_empty = (level_reg == '0);

    // Ready is held low during reset so nothing enters a FIFO that is being cleared.
    assign out_ready  = !inp_reset && (level_reg != LW'(FIFO_DEPTH));
    assign push       = inp_valid && out_ready;
    assign pop        = frame_load && !fifo_empty;
    assign head       = fifo_mem[rd_ptr_reg];

    assign out_mclk     = inp_clock;
    assign out_sclk     = tick_reg[3];
    assign out_wclk     = tick_reg[8];
    assign out_data     = data_reg;
    assign out_underrun = underrun_reg;
    assign out_level    = level_reg;

    // Free-running divider; wraps naturally from 0x1FF to 0x000.
    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + 9'd1;
        end
    end

    // Next shift-register value: reload at frame end, shift on sclk falls.
    // An empty FIFO loads silence rather than repeating stale audio.
    always_comb begin
        shreg_next = shreg_reg;
        if (frame_load) begin
            shreg_next = fifo_empty ? 32'h0 : head;
        end else if (sclk_fall) begin
            shreg_next = {shreg_reg[30:0], 1'b0};
        end
    end

    // Serial output register, shift register and underrun pulse.
    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            shreg_reg    <= '0;
            data_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            shreg_reg    <= shreg_next;
            underrun_reg <= frame_load && fifo_empty;
            if (sclk_fall) begin
                data_reg <= shreg_reg[31];
            end
        end
    end

    // FIFO storage write port; contents need no reset because level gates reads.
    always_ff @(posedge inp_clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {inp_left, inp_right};
        end
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge inp_clock) begin
        if (inp_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            level_reg <= level_next;
        end
    end

endmodule
